// File: rtl/axi_light_sram_slave_if.sv
// AXI-lite style bus (no resp fields) between a master and the SRAM slave.
interface axi_light_sram_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_light_sram_slave.sv
// Single-port word SRAM behind an AXI-lite style slave, one transaction at a time.
// Optional sticky out-of-range flag enabled by macro AXI_SRAM_RANGE_ERR_EN.
module axi_light_sram_slave #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          res_n,
  axi_light_sram_slave_if.slave         s_axi,
  output logic                          err
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, W_COLLECT, W_RESP, R_RESP} state_t;

  state_t      state;
  logic        aw_got;
  logic        w_got;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [3:0]  cap_strb;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [MEM_WORDS];

  logic             aw_hs, w_hs, ar_hs;
  logic             wr_en, wr_ok, rd_ok, mem_we;
  logic [31:0]      wr_addr, wr_data, wr_off, rd_off;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_prot;

  // Write has priority: reads are only offered when no write channel is active.
  assign s_axi.awready = (state == IDLE) || ((state == W_COLLECT) && !aw_got);
  assign s_axi.wready  = (state == IDLE) || ((state == W_COLLECT) && !w_got);
  assign s_axi.arready = (state == IDLE) && !s_axi.awvalid && !s_axi.wvalid;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // Select the address/data pair that commits this cycle, if any.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s_axi.awaddr;
    wr_data = s_axi.wdata;
    wr_strb = s_axi.wstrb;
    case (state)
      IDLE: wr_en = aw_hs && w_hs;
      W_COLLECT: begin
        if (aw_got && w_hs) begin
          wr_en   = 1'b1;
          wr_addr = cap_addr;
        end else if (w_got && aw_hs) begin
          wr_en   = 1'b1;
          wr_data = cap_data;
          wr_strb = cap_strb;
        end
      end
      default: ;
    endcase
  end

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range test.
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = s_axi.araddr - BASE_ADDR;
  assign wr_ok  = wr_off < MEM_BYTES;
  assign rd_ok  = rd_off < MEM_BYTES;
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_idx = rd_off[IDX_W+1:2];
  assign mem_we = wr_en && wr_ok && res_n;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_strb <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs && w_hs) begin
            bvalid_q <= 1'b1;
            state    <= W_RESP;
          end else if (aw_hs) begin
            aw_got   <= 1'b1;
            cap_addr <= s_axi.awaddr;
            state    <= W_COLLECT;
          end else if (w_hs) begin
            w_got    <= 1'b1;
            cap_data <= s_axi.wdata;
            cap_strb <= s_axi.wstrb;
            state    <= W_COLLECT;
          end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? mem[rd_idx] : 32'h0;
            state    <= R_RESP;
          end
        end
        W_COLLECT: begin
          if (wr_en) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_q <= 1'b1;
            state    <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_SRAM_RANGE_ERR_EN
  logic err_q;
  logic aw_oor;

  assign aw_oor = (s_axi.awaddr - BASE_ADDR) >= MEM_BYTES;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err_q <= 1'b0;
    end else if ((aw_hs && aw_oor) || (ar_hs && !rd_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/axi_light_sram_slave.md
AXI_LIGHT_SRAM_SLAVE -- requirements
Module: axi_light_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, giving the number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0 (MEM_WORDS*4 aligned).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port res_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports s_axi_awvalid/awready/awaddr/awprot: input 1 / output 1 / input 32 / input 3, the write address channel.
REQ-006 SHALL have ports s_axi_wvalid/wready/wdata/wstrb: input 1 / output 1 / input 32 / input 4, the write data channel.
REQ-007 SHALL have ports s_axi_bvalid/bready: output 1 / input 1, the write response (no bresp).
REQ-008 SHALL have ports s_axi_arvalid/arready/araddr/arprot: input 1 / output 1 / input 32 / input 3, the read address channel.
REQ-009 SHALL have ports s_axi_rvalid/rready/rdata: output 1 / input 1 / output 32, the read data channel (no rresp).
REQ-010 SHALL have port err  output  1  sticky out-of-range access flag.

Function
REQ-011 SHALL implement FSM states IDLE, W_COLLECT, W_RESP, R_RESP.
REQ-012 IDLE: awready=1, wready=1, arready=1 only when awvalid=0 and wvalid=0 (write wins simultaneous requests).
REQ-013 IDLE, aw and w handshake same cycle -> commit write that edge, go W_RESP.
REQ-014 IDLE, only one of aw/w handshakes -> capture it, go W_COLLECT; the captured channel's ready SHALL be 0 until it leaves W_COLLECT.
REQ-015 W_COLLECT: the missing channel's ready=1, arready=0; on its handshake commit the write with the captured address/data, go W_RESP.
REQ-016 Write commit SHALL update only the byte lanes with wstrb[i]=1; wstrb=0 SHALL leave memory unchanged but still produce a response.
REQ-017 W_RESP: bvalid=1, all readies 0; on bready=1 go IDLE; bvalid SHALL stay 1 and stable while bready=0.
REQ-018 IDLE, ar handshake -> go R_RESP; rvalid=1 and rdata=word at araddr on the next cycle (1-cycle latency).
REQ-019 R_RESP: rvalid and rdata SHALL hold stable until rready=1, then go IDLE; all readies 0 in R_RESP.
REQ-020 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; awprot/arprot ignored.
REQ-021 Address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4) SHALL be out of range: write dropped (response still issued), read returns rdata=32'h0.
REQ-022 Index arithmetic SHALL be 32-bit unsigned; addresses below BASE_ADDR wrap high and SHALL be treated as out of range, never aliased.
REQ-023 Throughput: a read SHALL complete in 2 cycles minimum (ar, r); a write in 2 cycles minimum (aw+w, b).
REQ-024 Memory contents SHALL be uninitialised after power-up and SHALL NOT be cleared by reset.

Reset
REQ-025 res_n=0 SHALL asynchronously force state IDLE, bvalid=0, rvalid=0, rdata=0, err=0, captured-channel flags cleared.
REQ-026 Reset mid-transaction SHALL abandon it; a write not yet committed SHALL NOT modify memory.
REQ-027 After res_n deassertion, the first rising edge SHALL already accept requests per REQ-012.

Configuration
REQ-028 Macro AXI_SRAM_RANGE_ERR_EN defined: err set to 1 on any out-of-range aw or ar handshake, held until reset.
REQ-029 Macro AXI_SRAM_RANGE_ERR_EN undefined: err tied to 0 and no range-error logic instantiated; REQ-021 still applies.

Verification
REQ-030 Write 32'hDEADBEEF to 0x10, wstrb=4'hF, then read 0x10 -> rdata=32'hDEADBEEF one cycle after ar handshake.
REQ-031 Word 0x20=32'h11223344, write 32'hAABBCCDD wstrb=4'b0101 -> read 0x20 returns 32'h11BB33DD.
REQ-032 awvalid 3 cycles before wvalid -> awready drops after aw handshake, memory commits only on w handshake, bvalid cycle after.
REQ-033 Hold bready=0 10 cycles, then rready=0 10 cycles on a read -> bvalid/rvalid and rdata stable, no new requests accepted.
REQ-034 With macro, read BASE_ADDR+MEM_WORDS*4 -> rdata=0, err=1 sticky; without macro err stays 0.
REQ-035 Assert res_n=0 after aw captured, before w -> no memory change, bvalid=0, state IDLE.
